hazard_scoreboard: RTL and testbench

Parametrised data-hazard unit for the 5-stage pipeline: generates per-read-port forwarding selects for the ID and EX stages and the store-data forward in MEM, and adds stall generation for load-use, ID-stage branch operands and a multi-cycle MUL/DIV unit. A one-entry scoreboard with a latency countdown tracks the MUL/DIV destination register. A saturating stall counter supports performance measurement. Sits beside the pipeline registers; its outputs drive the operand muxes and the PC / IF-ID enables.

---
 rtl/hazard_scoreboard_if.sv | 51 +++++
 rtl/hazard_scoreboard.sv | 127 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard: register addresses and enables
// from ID/EX/MEM/WB in, forwarding selects, stall and scoreboard status out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int NREAD  = 2,
  parameter int CNT_W  = 32
);
  logic                    id_valid;
  logic [NREAD*REG_AW-1:0] id_ra;
  logic [NREAD-1:0]        id_re;
  logic                    id_branch;
  logic                    id_md;
  logic [NREAD*REG_AW-1:0] ex_ra;
  logic [NREAD-1:0]        ex_re;
  logic                    ex_regwe;
  logic                    ex_memread;
  logic [REG_AW-1:0]       ex_rw;
  logic                    mem_regwe;
  logic                    mem_memread;
  logic                    mem_ramwe;
  logic [REG_AW-1:0]       mem_rw;
  logic [REG_AW-1:0]       mem_rt;
  logic                    wb_regwe;
  logic [REG_AW-1:0]       wb_rw;
  logic                    md_start;
  logic [REG_AW-1:0]       md_rw;
  logic                    flush;
  logic [2*NREAD-1:0]      id_fwd;
  logic [2*NREAD-1:0]      ex_fwd;
  logic                    mem_fwd;
  logic                    stall;
  logic                    md_busy;
  logic                    md_err;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output id_valid, id_ra, id_re, id_branch, id_md,
           ex_ra, ex_re, ex_regwe, ex_memread, ex_rw,
           mem_regwe, mem_memread, mem_ramwe, mem_rw, mem_rt,
           wb_regwe, wb_rw, md_start, md_rw, flush,
    input  id_fwd, ex_fwd, mem_fwd, stall, md_busy, md_err, stall_cnt
  );

  modport slave (
    input  id_valid, id_ra, id_re, id_branch, id_md,
           ex_ra, ex_re, ex_regwe, ex_memread, ex_rw,
           mem_regwe, mem_memread, mem_ramwe, mem_rw, mem_rt,
           wb_regwe, wb_rw, md_start, md_rw, flush,
    output id_fwd, ex_fwd, mem_fwd, stall, md_busy, md_err, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit: ID/EX operand forwarding, store-data forwarding, stall
// generation, a one-entry MUL/DIV latency scoreboard and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int NREAD  = 2,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] LAT_M1 = CW'(MD_LAT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [REG_AW-1:0] r_md_rw, w_md_rw_n;
  logic              r_err, w_err_n;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [2*NREAD-1:0] w_id_fwd, w_ex_fwd;
  logic w_m_ex, w_m_mem, w_m_md;
  logic w_md_act, w_ld_use, w_branch, w_md_raw, w_md_struct, w_stall;

  function automatic logic addr_match(input logic re, input logic [REG_AW-1:0] ra,
                                      input logic [REG_AW-1:0] x);
    return re && (ra != '0) && (ra == x);
  endfunction

  // MEM wins over WB: it holds the younger result for the same register.
  function automatic logic [1:0] fwd_sel(input logic re, input logic [REG_AW-1:0] ra,
                                         input logic mwe, input logic [REG_AW-1:0] mrw,
                                         input logic wwe, input logic [REG_AW-1:0] wrw);
    if (mwe && addr_match(re, ra, mrw)) return 2'b10;
    if (wwe && addr_match(re, ra, wrw)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    w_id_fwd = '0;
    w_ex_fwd = '0;
    w_m_ex   = 1'b0;
    w_m_mem  = 1'b0;
    w_m_md   = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      w_id_fwd[2*i +: 2] = fwd_sel(bus.id_re[i], bus.id_ra[i*REG_AW +: REG_AW],
                                   bus.mem_regwe, bus.mem_rw, bus.wb_regwe, bus.wb_rw);
      w_ex_fwd[2*i +: 2] = fwd_sel(bus.ex_re[i], bus.ex_ra[i*REG_AW +: REG_AW],
                                   bus.mem_regwe, bus.mem_rw, bus.wb_regwe, bus.wb_rw);
      w_m_ex  = w_m_ex  | addr_match(bus.id_re[i], bus.id_ra[i*REG_AW +: REG_AW], bus.ex_rw);
      w_m_mem = w_m_mem | addr_match(bus.id_re[i], bus.id_ra[i*REG_AW +: REG_AW], bus.mem_rw);
      w_m_md  = w_m_md  | addr_match(bus.id_re[i], bus.id_ra[i*REG_AW +: REG_AW], r_md_rw);
    end
  end

  // The cnt==0 cycle is the result write, covered by normal WB forwarding.
  assign w_md_act    = (r_state == S_BUSY) && (r_cnt != '0);
  assign w_ld_use    = bus.ex_memread & bus.ex_regwe & w_m_ex;
  assign w_branch    = bus.id_branch & ((bus.ex_regwe & w_m_ex) |
                                        (bus.mem_memread & bus.mem_regwe & w_m_mem));
  assign w_md_raw    = w_md_act & w_m_md;
  assign w_md_struct = w_md_act & bus.id_md;
  assign w_stall     = bus.id_valid & ~bus.flush &
                       (w_ld_use | w_branch | w_md_raw | w_md_struct);

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_md_rw_n = r_md_rw;
    w_err_n   = r_err;
    case (r_state)
      S_IDLE: begin
        if (bus.md_start) begin
          w_state_n = S_BUSY;
          w_cnt_n   = LAT_M1;
          w_md_rw_n = bus.md_rw;
        end
      end
      S_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - CW'(1);
          if (bus.md_start) w_err_n = 1'b1;
        end else if (bus.md_start) begin
          w_cnt_n   = LAT_M1;
          w_md_rw_n = bus.md_rw;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_md_rw     <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_md_rw <= w_md_rw_n;
      r_err   <= w_err_n;
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign bus.id_fwd    = w_id_fwd;
  assign bus.ex_fwd    = w_ex_fwd;
  assign bus.mem_fwd   = bus.wb_regwe & bus.mem_ramwe & (bus.mem_rt != '0) &
                         (bus.mem_rt == bus.wb_rw);
  assign bus.stall     = w_stall;
  assign bus.md_busy   = (r_state == S_BUSY);
  assign bus.md_err    = r_err;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: combinational vector table plus
// hand-written MUL/DIV, reset and counter-saturation sequences.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .NREAD(2), .CNT_W(32)) bus ();
  hazard_scoreboard_if #(.REG_AW(5), .NREAD(2), .CNT_W(4))  bus4 ();

  hazard_scoreboard #(.REG_AW(5), .NREAD(2), .MD_LAT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  hazard_scoreboard #(.REG_AW(5), .NREAD(2), .MD_LAT(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct packed {
    logic       id_valid; logic [9:0] id_ra; logic [1:0] id_re;
    logic       id_branch; logic id_md;
    logic [9:0] ex_ra; logic [1:0] ex_re; logic ex_regwe; logic ex_memread;
    logic [4:0] ex_rw;
    logic       mem_regwe; logic mem_memread; logic mem_ramwe;
    logic [4:0] mem_rw; logic [4:0] mem_rt;
    logic       wb_regwe; logic [4:0] wb_rw; logic flush;
    logic [3:0] e_id_fwd; logic [3:0] e_ex_fwd; logic e_mem_fwd; logic e_stall;
  } vec_t;

  typedef struct packed {
    logic [3:0] id_fwd; logic [3:0] ex_fwd; logic mem_fwd; logic stall;
  } exp_t;

  exp_t q[$];
  vec_t vt[16];
  int total = 0;
  int passed = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] idf, input logic [3:0] exf,
                          input logic mf, input logic st);
    exp_t e;
    e.id_fwd = idf; e.ex_fwd = exf; e.mem_fwd = mf; e.stall = st;
    q.push_back(e);
  endtask

  task automatic check_comb(input string nm);
    exp_t e;
    if (q.size() == 0) begin
      chk({nm, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({nm, ".id_fwd"},  32'(bus.id_fwd),  32'(e.id_fwd));
      chk({nm, ".ex_fwd"},  32'(bus.ex_fwd),  32'(e.ex_fwd));
      chk({nm, ".mem_fwd"}, 32'(bus.mem_fwd), 32'(e.mem_fwd));
      chk({nm, ".stall"},   32'(bus.stall),   32'(e.stall));
    end
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid = v.id_valid; bus.id_ra = v.id_ra; bus.id_re = v.id_re;
    bus.id_branch = v.id_branch; bus.id_md = v.id_md;
    bus.ex_ra = v.ex_ra; bus.ex_re = v.ex_re; bus.ex_regwe = v.ex_regwe;
    bus.ex_memread = v.ex_memread; bus.ex_rw = v.ex_rw;
    bus.mem_regwe = v.mem_regwe; bus.mem_memread = v.mem_memread;
    bus.mem_ramwe = v.mem_ramwe; bus.mem_rw = v.mem_rw; bus.mem_rt = v.mem_rt;
    bus.wb_regwe = v.wb_regwe; bus.wb_rw = v.wb_rw; bus.flush = v.flush;
  endtask

  task automatic zero_all();
    vec_t z;
    z = '0;
    drive(z);
    bus.md_start = 1'b0; bus.md_rw = '0;
    bus4.id_valid = 0; bus4.id_ra = '0; bus4.id_re = '0; bus4.id_branch = 0;
    bus4.id_md = 0; bus4.ex_ra = '0; bus4.ex_re = '0; bus4.ex_regwe = 0;
    bus4.ex_memread = 0; bus4.ex_rw = '0; bus4.mem_regwe = 0; bus4.mem_memread = 0;
    bus4.mem_ramwe = 0; bus4.mem_rw = '0; bus4.mem_rt = '0; bus4.wb_regwe = 0;
    bus4.wb_rw = '0; bus4.md_start = 0; bus4.md_rw = '0; bus4.flush = 0;
  endtask

  task automatic do_reset();
    zero_all();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic fill_table();
    vec_t v;
    // 0: idle
    v = '0; vt[0] = v;
    // 1: EX writes r3, ID reads r3 on port 1, nothing in MEM
    v = '0; v.id_valid = 1; v.id_re = 2'b10; v.id_ra = {5'd3, 5'd0};
    v.ex_regwe = 1; v.ex_rw = 5'd3; vt[1] = v;
    // 2: EX reads r3 on port 1, MEM writes r3
    v = '0; v.ex_re = 2'b10; v.ex_ra = {5'd3, 5'd0}; v.mem_regwe = 1; v.mem_rw = 5'd3;
    v.e_ex_fwd = 4'b1000; vt[2] = v;
    // 3: same register in MEM and WB: MEM wins, on ID port 0 too
    v = '0; v.ex_re = 2'b10; v.ex_ra = {5'd3, 5'd0}; v.mem_regwe = 1; v.mem_rw = 5'd3;
    v.wb_regwe = 1; v.wb_rw = 5'd3; v.id_valid = 1; v.id_re = 2'b01; v.id_ra = {5'd0, 5'd3};
    v.e_ex_fwd = 4'b1000; v.e_id_fwd = 4'b0010; vt[3] = v;
    // 4: WB-only match on EX port 0
    v = '0; v.ex_re = 2'b01; v.ex_ra = {5'd0, 5'd4}; v.wb_regwe = 1; v.wb_rw = 5'd4;
    v.mem_regwe = 1; v.mem_rw = 5'd5; v.e_ex_fwd = 4'b0001; vt[4] = v;
    // 5: r0 never forwarded
    v = '0; v.ex_re = 2'b01; v.mem_regwe = 1; vt[5] = v;
    // 6: read enable off
    v = '0; v.ex_ra = {5'd0, 5'd6}; v.mem_regwe = 1; v.mem_rw = 5'd6; vt[6] = v;
    // 7: store data from WB
    v = '0; v.wb_regwe = 1; v.wb_rw = 5'd8; v.mem_ramwe = 1; v.mem_rt = 5'd8;
    v.e_mem_fwd = 1; vt[7] = v;
    // 8: store of r0
    v = '0; v.wb_regwe = 1; v.mem_ramwe = 1; vt[8] = v;
    // 9: load-use on rs
    v = '0; v.id_valid = 1; v.id_re = 2'b01; v.id_ra = {5'd0, 5'd5};
    v.ex_memread = 1; v.ex_regwe = 1; v.ex_rw = 5'd5; v.e_stall = 1; vt[9] = v;
    // 10: load-use pattern but rs = r0
    v = '0; v.id_valid = 1; v.id_re = 2'b01; v.ex_memread = 1; v.ex_regwe = 1;
    v.ex_rw = 5'd5; vt[10] = v;
    // 11: load-use pattern with no live ID instruction
    v = '0; v.id_re = 2'b01; v.id_ra = {5'd0, 5'd5}; v.ex_memread = 1; v.ex_regwe = 1;
    v.ex_rw = 5'd5; vt[11] = v;
    // 12: branch reads rt produced in EX
    v = '0; v.id_valid = 1; v.id_branch = 1; v.id_re = 2'b10; v.id_ra = {5'd9, 5'd0};
    v.ex_regwe = 1; v.ex_rw = 5'd9; v.e_stall = 1; vt[12] = v;
    // 13: same with flush
    v = vt[12]; v.flush = 1; v.e_stall = 0; vt[13] = v;
    // 14: branch reads rt loaded in MEM
    v = '0; v.id_valid = 1; v.id_branch = 1; v.id_re = 2'b10; v.id_ra = {5'd9, 5'd0};
    v.mem_memread = 1; v.mem_regwe = 1; v.mem_rw = 5'd9; v.e_stall = 1;
    v.e_id_fwd = 4'b1000; vt[14] = v;
    // 15: ALU result in EX, non-branch reader
    v = '0; v.id_valid = 1; v.id_re = 2'b10; v.id_ra = {5'd9, 5'd0};
    v.ex_regwe = 1; v.ex_rw = 5'd9; vt[15] = v;
  endtask

  initial begin
    zero_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.md_busy", 32'(bus.md_busy), 32'd0);
    chk("rst.md_err", 32'(bus.md_err), 32'd0);
    chk("rst.stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst.stall_cnt4", 32'(bus4.stall_cnt), 32'd0);
    rst_n = 1'b1;

    fill_table();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vt[i]);
      push_exp(vt[i].e_id_fwd, vt[i].e_ex_fwd, vt[i].e_mem_fwd, vt[i].e_stall);
      #1 check_comb($sformatf("vec%0d", i));
    end
    @(negedge clk);
    zero_all();
    #1 chk("table.stall_cnt", bus.stall_cnt, 32'd3);

    // MUL/DIV RAW: md_start r7 at t, reader stalls t+1..t+3, WB forward at t+4
    do_reset();
    @(negedge clk); bus.md_start = 1; bus.md_rw = 5'd7;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.md_start = 0; bus.id_valid = 1; bus.id_re = 2'b01; bus.id_ra = {5'd0, 5'd7};
      push_exp(4'b0000, 4'b0000, 1'b0, 1'b1);
      #1 check_comb($sformatf("mdraw_t%0d", k));
    end
    @(negedge clk); bus.wb_regwe = 1; bus.wb_rw = 5'd7;
    push_exp(4'b0001, 4'b0000, 1'b0, 1'b0);
    #1 check_comb("mdraw_t4");
    chk("mdraw_t4.md_busy", 32'(bus.md_busy), 32'd1);
    @(negedge clk); zero_all();
    #1 chk("mdraw_t5.md_busy", 32'(bus.md_busy), 32'd0);
    chk("mdraw_t5.stall_cnt", bus.stall_cnt, 32'd3);

    // Structural stall, ignored md_start while busy, reload on last cycle
    do_reset();
    @(negedge clk); bus.md_start = 1; bus.md_rw = 5'd10;
    @(negedge clk); bus.md_start = 0;
    #1 chk("md1.md_busy", 32'(bus.md_busy), 32'd1);
    chk("md1.md_err", 32'(bus.md_err), 32'd0);
    @(negedge clk); bus.id_valid = 1; bus.id_md = 1; bus.md_start = 1; bus.md_rw = 5'd11;
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1 check_comb("md_struct");
    @(negedge clk); bus.id_md = 0; bus.md_start = 0; bus.id_re = 2'b01;
    bus.id_ra = {5'd0, 5'd11};
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b0);
    #1 check_comb("md_ignored");
    chk("md3.md_err", 32'(bus.md_err), 32'd1);
    @(negedge clk); bus.id_re = 2'b00; bus.md_start = 1; bus.md_rw = 5'd12;
    bus.wb_regwe = 1; bus.wb_rw = 5'd10;
    #1 chk("md4.md_busy", 32'(bus.md_busy), 32'd1);
    @(negedge clk); bus.md_start = 0; bus.wb_regwe = 0; bus.id_re = 2'b01;
    bus.id_ra = {5'd0, 5'd12};
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1 check_comb("md_reload");
    chk("md5.md_busy", 32'(bus.md_busy), 32'd1);
    chk("md5.md_err", 32'(bus.md_err), 32'd1);

    // Asynchronous reset in the middle of a MUL/DIV
    do_reset();
    @(negedge clk); bus.md_start = 1; bus.md_rw = 5'd7;
    @(negedge clk); bus.md_rw = 5'd8; bus.id_valid = 1; bus.id_re = 2'b01;
    bus.id_ra = {5'd0, 5'd7};
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1 check_comb("arst_pre");
    @(negedge clk); bus.md_start = 0;
    #1 chk("arst_pre.md_err", 32'(bus.md_err), 32'd1);
    chk("arst_pre.stall_cnt", bus.stall_cnt, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("arst.md_busy", 32'(bus.md_busy), 32'd0);
    chk("arst.md_err", 32'(bus.md_err), 32'd0);
    chk("arst.stall_cnt", bus.stall_cnt, 32'd0);
    push_exp(4'b0000, 4'b0000, 1'b0, 1'b0);
    check_comb("arst_comb");
    @(negedge clk); rst_n = 1'b1;

    // Counter saturation on the 4-bit instance
    do_reset();
    @(negedge clk);
    bus4.id_valid = 1; bus4.id_re = 2'b01; bus4.id_ra = {5'd0, 5'd5};
    bus4.ex_memread = 1; bus4.ex_regwe = 1; bus4.ex_rw = 5'd5;
    repeat (10) @(negedge clk);
    #1 chk("sat.cnt10", 32'(bus4.stall_cnt), 32'd10);
    repeat (10) @(negedge clk);
    zero_all();
    #1 chk("sat.cnt20", 32'(bus4.stall_cnt), 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
